// File: rtl/sram_arbiter_2p.sv
// Two-port round-robin arbiter and byte-transaction sequencer in front of the
// single SRAM access controller; supports locked bursts and an ack timeout.
module sram_arbiter_2p #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_p0_stb,
  input  logic                  i_p0_write,
  input  logic                  i_p0_lock,
  input  logic [ADDR_WIDTH-1:0] i_p0_addr,
  input  logic [DATA_WIDTH-1:0] i_p0_data,
  output logic                  o_p0_ack,
  output logic                  o_p0_err,
  output logic [DATA_WIDTH-1:0] o_p0_data,
  input  logic                  i_p1_stb,
  input  logic                  i_p1_write,
  input  logic                  i_p1_lock,
  input  logic [ADDR_WIDTH-1:0] i_p1_addr,
  input  logic [DATA_WIDTH-1:0] i_p1_data,
  output logic                  o_p1_ack,
  output logic                  o_p1_err,
  output logic [DATA_WIDTH-1:0] o_p1_data,
  output logic                  o_s_stb,
  output logic                  o_s_write,
  output logic [ADDR_WIDTH-1:0] o_s_addr,
  output logic [DATA_WIDTH-1:0] o_s_data,
  input  logic                  i_s_ack,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  output logic [1:0]            o_grant,
  output logic                  o_busy
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_RESP, S_GAP, S_ABORT} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  rr_q, rr_d;
  logic [BW-1:0]         burst_q, burst_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  s_write_q, s_write_d;
  logic [ADDR_WIDTH-1:0] s_addr_q, s_addr_d;
  logic [DATA_WIDTH-1:0] s_data_q, s_data_d;
  logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_WIDTH-1:0] p1_rdata_q, p1_rdata_d;
  logic                  load;
  logic                  release_own;
  logic                  owner_stb;
  logic                  owner_lock;

  assign owner_stb  = owner_q ? i_p1_stb  : i_p0_stb;
  assign owner_lock = owner_q ? i_p1_lock : i_p0_lock;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      rr_q       <= 1'b0;
      burst_q    <= '0;
      tmo_q      <= '0;
      s_write_q  <= 1'b0;
      s_addr_q   <= '0;
      s_data_q   <= '0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      burst_q    <= burst_d;
      tmo_q      <= tmo_d;
      s_write_q  <= s_write_d;
      s_addr_q   <= s_addr_d;
      s_data_q   <= s_data_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    burst_d     = burst_q;
    tmo_d       = tmo_q;
    s_write_d   = s_write_q;
    s_addr_d    = s_addr_q;
    s_data_d    = s_data_q;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    load        = 1'b0;
    release_own = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_p0_stb || i_p1_stb) begin
          owner_d = (i_p0_stb && i_p1_stb) ? rr_q : i_p1_stb;
          load    = 1'b1;
          tmo_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_s_ack) begin
          if (owner_q) p1_rdata_d = i_s_data;
          else         p0_rdata_d = i_s_data;
          state_d = S_RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TW'(TIMEOUT)) state_d = S_ABORT;
        end
      end
      S_RESP: begin
        // Count is post-increment, so a grant yields at most MAX_BURST transactions.
        burst_d = burst_q + 1'b1;
        if (owner_lock && (burst_d < BW'(MAX_BURST))) state_d = S_GAP;
        else                                          release_own = 1'b1;
      end
      S_GAP: begin
        if (owner_stb) begin
          load    = 1'b1;
          tmo_d   = '0;
          state_d = S_ISSUE;
        end else begin
          release_own = 1'b1;
        end
      end
      S_ABORT: release_own = 1'b1;
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      s_write_d = owner_d ? i_p1_write : i_p0_write;
      s_addr_d  = owner_d ? i_p1_addr  : i_p0_addr;
      s_data_d  = owner_d ? i_p1_data  : i_p0_data;
    end

    if (release_own) begin
      rr_d    = ~owner_q;
      burst_d = '0;
      state_d = S_IDLE;
    end
  end

  assign o_s_stb   = (state_q == S_ISSUE);
  assign o_s_write = s_write_q;
  assign o_s_addr  = s_addr_q;
  assign o_s_data  = s_data_q;
  assign o_p0_ack  = (state_q == S_RESP)  && !owner_q;
  assign o_p1_ack  = (state_q == S_RESP)  &&  owner_q;
  assign o_p0_err  = (state_q == S_ABORT) && !owner_q;
  assign o_p1_err  = (state_q == S_ABORT) &&  owner_q;
  assign o_p0_data = p0_rdata_q;
  assign o_p1_data = p1_rdata_q;
  assign o_busy    = (state_q != S_IDLE);
  assign o_grant   = (state_q == S_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
endmodule
